// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller sitting between the bridge and CP0.
// Holds MASK/PEND/MODE registers, edge/level capture per source, and a
// small IDLE/REQ/SERVICE FSM that raises intreq and tracks the serviced id.
// Optional build macro: IRQ_SYNC_EN adds a two-flop synchronizer on src.
module irq_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic            int_ack,
  output logic [NSRC-1:0] hwint,
  output logic            intreq
);

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_MODE = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  logic [NSRC-1:0] r_mask, r_pend, r_mode, r_src_q;
  logic [2:0]      r_cur_id;
  state_t          r_state, w_state_nxt;

  logic [NSRC-1:0] w_src, w_rise, w_clr, w_pend_nxt;
  logic [2:0]      w_top_id;
  logic            w_hit, w_cur_live;

`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] r_sync1, r_sync2;

  // Two-flop synchronizer so asynchronous sources never feed the edge logic directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = src;
`endif

  // Edge mode: rise sets, W1C clears, set beats clear. Level mode: follow src.
  assign w_rise     = w_src & ~r_src_q;
  assign w_clr      = (we && addr == A_PEND) ? wdata[NSRC-1:0] : '0;
  assign w_pend_nxt = (r_mode & (w_rise | (r_pend & ~w_clr))) | (~r_mode & w_src);

  assign hwint      = r_pend & r_mask;
  assign w_hit      = |hwint;
  assign w_cur_live = r_pend[r_cur_id] & r_mask[r_cur_id];
  assign intreq     = (r_state == REQ);

  // Highest-index pending source wins the id capture.
  always_comb begin
    w_top_id = '0;
    for (int i = 0; i < NSRC; i++)
      if (hwint[i]) w_top_id = 3'(i);
  end

  // Register file, source sample and pending capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask  <= '0;
      r_mode  <= '0;
      r_pend  <= '0;
      r_src_q <= '0;
    end else begin
      r_src_q <= w_src;
      r_pend  <= w_pend_nxt;
      if (we && addr == A_MASK) r_mask <= wdata[NSRC-1:0];
      if (we && addr == A_MODE) r_mode <= wdata[NSRC-1:0];
    end
  end

  // FSM state and serviced-id capture on acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cur_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == REQ && w_hit && int_ack) r_cur_id <= w_top_id;
    end
  end

  // Next-state: acknowledge only counts while requesting with something pending.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hit) w_state_nxt = REQ;
      REQ: begin
        if (!w_hit)       w_state_nxt = IDLE;
        else if (int_ack) w_state_nxt = SERVICE;
      end
      SERVICE: if (!w_cur_live) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Combinational register read; unused upper bits read as zero.
  always_comb begin
    rdata = '0;
    case (addr)
      A_MASK: rdata[NSRC-1:0] = r_mask;
      A_PEND: rdata[NSRC-1:0] = r_pend;
      A_MODE: rdata[NSRC-1:0] = r_mode;
      A_STAT: begin
        rdata[5:4] = r_state;
        rdata[2:0] = r_cur_id;
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus pushes expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 0;
  logic        reset;
  logic [5:0]  src;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        int_ack;
  logic [5:0]  hwint;
  logic        intreq;

  irq_ctrl #(.NSRC(6)) dut (
    .clk(clk), .reset(reset), .src(src), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .int_ack(int_ack), .hwint(hwint), .intreq(intreq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 rdata, 1 hwint, 2 intreq
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: every pending expectation is compared at the falling edge.
  always @(negedge clk) begin
    exp_t        it;
    logic [31:0] act;
    while (q.size() > 0) begin
      it = q.pop_front();
      case (it.kind)
        0:       act = rdata;
        1:       act = {26'd0, hwint};
        default: act = {31'd0, intreq};
      endcase
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", it.name, act, it.exp);
      end
    end
  end

  task automatic push(input int kind, input logic [31:0] e, input string n);
    exp_t it;
    it.kind = kind; it.exp = e; it.name = n;
    q.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    repeat (LAT-1) tick();
  endtask

  task automatic sync_chk();
    @(negedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
    addr = a;
    push(0, e, n);
    sync_chk();
  endtask

  initial begin
    reset = 1; src = 0; addr = 0; we = 0; wdata = 0; int_ack = 0;
    tick(); tick();
    reset = 0;

    // Reset state
    push(1, 0, "rst_hwint"); push(2, 0, "rst_intreq");
    rd(0, 0, "rst_mask");
    rd(1, 0, "rst_pend");
    rd(2, 0, "rst_mode");
    rd(3, 0, "rst_stat");

    // Edge-mode pulse on src[2]
    wr(2, 32'h04); wr(0, 32'h04);
    src = 6'h04; tick(); src = 0; settle();
    push(1, 32'h04, "pulse_hwint"); push(2, 0, "pulse_intreq_early");
    rd(1, 32'h04, "pulse_pend");
    tick();
    push(2, 1, "pulse_intreq"); push(1, 32'h04, "pulse_hwint_hold");
    sync_chk();

    // Acknowledge, then W1C returns FSM to IDLE
    int_ack = 1; tick(); int_ack = 0;
    push(2, 0, "svc_intreq");
    rd(3, 32'h22, "svc_stat");
    wr(1, 32'h04);
    rd(1, 0, "w1c_pend");
    tick();
    push(2, 0, "idle_intreq");
    rd(3, 32'h02, "idle_stat");
    tick();
    push(2, 0, "idle_intreq_hold");
    sync_chk();

    // Set beats simultaneous W1C
    src = 6'h04; tick(); src = 0; settle(); tick();
    src = 6'h04; settle();
    wr(1, 32'h04);
    push(1, 32'h04, "setwin_hwint");
    rd(1, 32'h04, "setwin_pend");
    src = 0;
    wr(1, 32'h04);
    rd(1, 0, "clr_pend");
    tick();
    push(2, 0, "req_drop_intreq");
    sync_chk();

    // Level mode, priority capture and re-request
    wr(2, 0); wr(0, 32'h3F);
    src = 6'h09; tick(); settle();
    push(1, 32'h09, "lvl_hwint");
    rd(1, 32'h09, "lvl_pend");
    tick();
    push(2, 1, "lvl_intreq");
    sync_chk();
    int_ack = 1; tick(); int_ack = 0;
    rd(3, 32'h23, "lvl_stat_id3");
    src = 6'h01; tick(); settle();
    rd(1, 32'h01, "lvl_pend_drop");
    tick();
    push(2, 0, "lvl_idle_intreq");
    rd(3, 32'h03, "lvl_idle_stat");
    tick();
    push(2, 1, "lvl_rereq_intreq");
    sync_chk();
    int_ack = 1; tick(); int_ack = 0;
    rd(3, 32'h20, "lvl_stat_id0");
    wr(1, 32'h01);
    rd(1, 32'h01, "lvl_pend_nowrite");
    int_ack = 1; tick(); int_ack = 0;
    rd(3, 32'h20, "svc_ack_ignored");

    // Reset mid-service with everything pending
    src = 6'h3F; tick(); settle();
    push(1, 32'h3F, "pre_rst_hwint");
    rd(1, 32'h3F, "pre_rst_pend");
    reset = 1; src = 0; tick(); reset = 0;
    push(1, 0, "post_rst_hwint"); push(2, 0, "post_rst_intreq");
    rd(3, 0, "post_rst_stat");
    rd(0, 0, "post_rst_mask");
    rd(1, 0, "post_rst_pend");
    rd(2, 0, "post_rst_mode");

    // Idle ack ignored, upper bits zero, STAT read-only
    int_ack = 1; tick(); int_ack = 0;
    rd(3, 0, "idle_ack_ignored");
    wr(0, 32'hFFFF_FFFF);
    rd(0, 32'h3F, "mask_upper_zero");
    wr(3, 32'hFFFF_FFFF);
    rd(3, 0, "stat_readonly");

    sync_chk();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter: NSRC, 6, number of interrupt sources; it SHALL match the CP0 HWInt field width.
REQ-002 Port: clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 Port: reset  input  1  reset; it SHALL be synchronous and active-high.
REQ-004 Port: src  input  NSRC  raw interrupt sources from the timers and the external interrupt pin.
REQ-005 Port: addr  input  2  register select from the bridge: 0 MASK, 1 PEND, 2 MODE, 3 STAT.
REQ-006 Port: we  input  1  bridge write strobe for one cycle.
REQ-007 Port: wdata  input  32  bridge write data.
REQ-008 Port: rdata  output  32  read data, combinational from addr.
REQ-009 Port: int_ack  input  1  one-cycle pulse from CP0 on exception entry for an interrupt.
REQ-010 Port: hwint  output  NSRC  masked pending vector to CP0 (PEND & MASK).
REQ-011 Port: intreq  output  1  service request to CP0.

Function
REQ-012 MASK, PEND, MODE SHALL be NSRC-bit registers in wdata[NSRC-1:0]; upper rdata bits SHALL read 0.
REQ-013 MODE bit 1 selects edge mode; MODE bit 0 selects level mode.
REQ-014 Edge mode: PEND[i] SHALL set at edge k when src[i]=1 at k and the src sample register held 0; visible in the cycle after edge k.
REQ-015 Edge mode: a write to PEND with wdata[i]=1 SHALL clear PEND[i]; a simultaneous set SHALL win.
REQ-016 Level mode: PEND[i] SHALL load src[i] every edge; PEND writes SHALL have no effect on that bit.
REQ-017 A MODE change SHALL take effect from the next edge; PEND SHALL keep its value across the switch.
REQ-018 hwint SHALL be combinational PEND & MASK; src-to-hwint latency SHALL be 1 cycle.
REQ-019 FSM states: IDLE(0), REQ(1), SERVICE(2); intreq SHALL be 1 only in REQ.
REQ-020 IDLE->REQ when |hwint; REQ->IDLE when hwint becomes 0 before int_ack.
REQ-021 REQ->SERVICE on int_ack; cur_id SHALL capture the highest set index of hwint on that same edge.
REQ-022 SERVICE->IDLE when PEND[cur_id]=0 or MASK[cur_id]=0; if hwint is still nonzero, the FSM SHALL go to REQ one cycle later.
REQ-023 int_ack in IDLE or SERVICE SHALL be ignored.
REQ-024 STAT read: bits[2:0]=cur_id, bits[5:4]=state, other bits 0; STAT writes SHALL be ignored.

Reset
REQ-025 On reset: MASK, PEND, MODE, cur_id and src sample registers SHALL be 0; state SHALL be IDLE; intreq and hwint SHALL be 0.
REQ-026 Reset asserted in any state, including mid-service, SHALL override every other input on that edge.

Configuration
REQ-027 With IRQ_SYNC_EN defined: src SHALL pass through a two-flop synchronizer before edge and level logic, making src-to-hwint latency 3 cycles; the synchronizer flops SHALL reset to 0.
REQ-028 Without IRQ_SYNC_EN: src SHALL be used directly, with latency 1 cycle per REQ-018.

Verification
REQ-029 MODE=0x04, MASK=0x04, src[2] pulses one cycle -> PEND=0x04 and hwint=0x04 next cycle, then intreq=1.
REQ-030 From REQ-029, pulse int_ack -> STAT=0x22; write PEND=0x04 -> PEND=0, FSM returns to IDLE, intreq stays 0.
REQ-031 Edge mode, PEND W1C on the same edge as a new src[2] rise -> PEND[2] stays 1.
REQ-032 MODE=0, MASK=0x3F, src=0x09 held, int_ack -> cur_id=3; src drops to 0x01 -> IDLE then REQ; next int_ack -> cur_id=0.
REQ-033 Reset asserted in SERVICE with PEND=0x3F -> next cycle all registers 0, STAT=0, intreq=0.
REQ-034 Build with IRQ_SYNC_EN, src[2] rise in edge mode -> hwint[2] asserts 3 cycles after the rise.
